// File: rtl/digi_pkg.sv
// Shared types and constants for the multi-channel capture path.
package digi_pkg;

    localparam int unsigned DEFAULT_WIDTH      = 12;
    localparam int unsigned DEFAULT_DEPTH_LOG2 = 10;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StPost,
        StReadout
    } cap_state_e;

    // Channel index width; never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: synchronous write, one-cycle registered read.
module capture_ram
    import digi_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Read data holds while re is low so the top can stall the read pipeline.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/multi_channel_capture.sv
// N-channel triggered capture with pre/post-trigger window and channel-ordered
// valid/ready readout.
module multi_channel_capture
    import digi_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    localparam int unsigned CH_W      = ch_width(N_CH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_valid,
    input  logic [N_CH*WIDTH-1:0] sample_data,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  ext_trigger,
    input  logic                  self_trig_en,
    input  logic [WIDTH-1:0]      threshold,
    input  logic [N_CH-1:0]       trig_ch_mask,
    input  logic [DEPTH_LOG2:0]   pre_count,
    input  logic [DEPTH_LOG2:0]   post_count,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [WIDTH-1:0]      rd_data,
    output logic [CH_W-1:0]       rd_ch,
    output logic                  rd_last,
    output logic                  armed,
    output logic                  done
);

    localparam int unsigned CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(2 ** DEPTH_LOG2);

    cap_state_e state_q, state_d;

    logic [DEPTH_LOG2-1:0] wp_q, wp_d, start_q, start_d, iss_addr_q, iss_addr_d;
    logic [CW-1:0]         pre_q, pre_d, post_q, post_d, fill_q, fill_d, left_q, left_d;
    logic [CW-1:0]         iss_cnt_q, iss_cnt_d;
    logic [CH_W-1:0]       iss_ch_q, iss_ch_d, s1_ch_q, s1_ch_d, rd_ch_q, rd_ch_d;
    logic                  iss_pend_q, iss_pend_d, s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic                  rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, done_q, done_d;
    logic [WIDTH-1:0]      rd_data_q, rd_data_d;

    logic [CW-1:0]    pre_clamp, post_room, post_clamp, len;
    logic [N_CH-1:0]  self_hit;
    logic             trig, accept, we, re, out_ready, handshake, iss_last, iss_ch_end;
    logic [WIDTH-1:0] ram_rdata [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign self_hit[k] = trig_ch_mask[k] && (sample_data[k*WIDTH +: WIDTH] >= threshold);

        capture_ram #(
            .WIDTH      (WIDTH),
            .DEPTH_LOG2 (DEPTH_LOG2)
        ) u_ram (
            .clk   (clk),
            .we    (we),
            .waddr (wp_q),
            .wdata (sample_data[k*WIDTH +: WIDTH]),
            .re    (re),
            .raddr (iss_addr_q),
            .rdata (ram_rdata[k])
        );
    end

    // Window never exceeds the buffer: pre is capped first, post gets what is left.
    assign pre_clamp  = (pre_count > DEPTH_C) ? DEPTH_C : pre_count;
    assign post_room  = DEPTH_C - pre_clamp;
    assign post_clamp = (post_count > post_room) ? post_room : post_count;

    assign trig       = ext_trigger || (self_trig_en && sample_valid && (|self_hit));
    assign accept     = (state_q == StArmed) && (fill_q == pre_q) && trig;
    assign len        = pre_q + post_q;
    assign out_ready  = !rd_valid_q || rd_ready;
    assign handshake  = rd_valid_q && rd_ready;
    assign iss_ch_end = (iss_cnt_q == len - CW'(1));
    assign iss_last   = (iss_ch_q == CH_W'(N_CH - 1)) && iss_ch_end;
    assign re         = (state_q == StReadout) && iss_pend_q && (!s1_valid_q || out_ready);

    always_comb begin
        state_d    = state_q;
        wp_d       = wp_q;
        start_d    = start_q;
        iss_addr_d = iss_addr_q;
        pre_d      = pre_q;
        post_d     = post_q;
        fill_d     = fill_q;
        left_d     = left_q;
        iss_cnt_d  = iss_cnt_q;
        iss_ch_d   = iss_ch_q;
        iss_pend_d = iss_pend_q;
        s1_valid_d = s1_valid_q;
        s1_ch_d    = s1_ch_q;
        s1_last_d  = s1_last_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_ch_d    = rd_ch_q;
        rd_last_d  = rd_last_q;
        done_d     = 1'b0;
        we         = 1'b0;

        unique case (state_q)
            StIdle: begin
                wp_d = '0;
                if (arm) begin
                    pre_d   = pre_clamp;
                    post_d  = post_clamp;
                    fill_d  = '0;
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (accept) begin
                    start_d    = wp_q - pre_q[DEPTH_LOG2-1:0];
                    iss_addr_d = wp_q - pre_q[DEPTH_LOG2-1:0];
                    iss_ch_d   = '0;
                    iss_cnt_d  = '0;
                    iss_pend_d = (len != '0);
                    // With no post window the trigger-cycle sample must not land on
                    // the oldest pre sample, so it is dropped.
                    if (post_q == '0) begin
                        state_d = StReadout;
                    end else begin
                        we      = sample_valid;
                        left_d  = post_q - CW'(sample_valid);
                        state_d = (post_q == CW'(sample_valid)) ? StReadout : StPost;
                    end
                end else if (sample_valid) begin
                    we     = 1'b1;
                    fill_d = (fill_q == pre_q) ? fill_q : fill_q + CW'(1);
                end
            end
            StPost: begin
                if (sample_valid) begin
                    we     = 1'b1;
                    left_d = left_q - CW'(1);
                    if (left_q == CW'(1)) begin
                        state_d = StReadout;
                    end
                end
            end
            StReadout: begin
                if (len == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
                if (re) begin
                    s1_valid_d = 1'b1;
                    s1_ch_d    = iss_ch_q;
                    s1_last_d  = iss_last;
                    if (iss_last) begin
                        iss_pend_d = 1'b0;
                    end else if (iss_ch_end) begin
                        iss_ch_d   = iss_ch_q + CH_W'(1);
                        iss_cnt_d  = '0;
                        iss_addr_d = start_q;
                    end else begin
                        iss_cnt_d  = iss_cnt_q + CW'(1);
                        iss_addr_d = iss_addr_q + DEPTH_LOG2'(1);
                    end
                end else if (s1_valid_q && out_ready) begin
                    s1_valid_d = 1'b0;
                end
                if (out_ready) begin
                    rd_valid_d = s1_valid_q;
                    if (s1_valid_q) begin
                        rd_data_d = ram_rdata[s1_ch_q];
                        rd_ch_d   = s1_ch_q;
                        rd_last_d = s1_last_q;
                    end
                end
                if (handshake && rd_last_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d = StIdle;
            done_d  = 1'b0;
            we      = 1'b0;
        end
        if (state_d != StReadout) begin
            rd_valid_d = 1'b0;
            s1_valid_d = 1'b0;
        end
        if (we) begin
            wp_d = wp_q + DEPTH_LOG2'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wp_q       <= '0;
            start_q    <= '0;
            iss_addr_q <= '0;
            pre_q      <= '0;
            post_q     <= '0;
            fill_q     <= '0;
            left_q     <= '0;
            iss_cnt_q  <= '0;
            iss_ch_q   <= '0;
            iss_pend_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s1_last_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ch_q    <= '0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            start_q    <= start_d;
            iss_addr_q <= iss_addr_d;
            pre_q      <= pre_d;
            post_q     <= post_d;
            fill_q     <= fill_d;
            left_q     <= left_d;
            iss_cnt_q  <= iss_cnt_d;
            iss_ch_q   <= iss_ch_d;
            iss_pend_q <= iss_pend_d;
            s1_valid_q <= s1_valid_d;
            s1_ch_q    <= s1_ch_d;
            s1_last_q  <= s1_last_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ch_q    <= rd_ch_d;
            rd_last_q  <= rd_last_d;
            done_q     <= done_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_ch    = rd_ch_q;
    assign rd_last  = rd_last_q;
    assign done     = done_q;
    assign armed    = (state_q == StArmed) || (state_q == StPost);

endmodule

// File: tb/tb_multi_channel_capture.sv
// Scoreboard bench: the driver models the capture window from the sample history and
// queues expected words; a monitor checks every word the DUT offers.
module tb_multi_channel_capture;

    localparam int N_CH       = 4;
    localparam int WIDTH      = 12;
    localparam int DEPTH_LOG2 = 4;
    localparam int CH_W       = 2;
    localparam int CW         = DEPTH_LOG2 + 1;
    localparam int DEPTH      = 16;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  sample_valid, arm, abort, ext_trigger, self_trig_en, rd_ready;
    logic [N_CH*WIDTH-1:0] sample_data;
    logic [WIDTH-1:0]      threshold;
    logic [N_CH-1:0]       trig_ch_mask;
    logic [CW-1:0]         pre_count, post_count;
    logic                  rd_valid, rd_last, armed, done;
    logic [WIDTH-1:0]      rd_data;
    logic [CH_W-1:0]       rd_ch;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic             last;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   ext_list[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   ready_pct   = 100;
    bit   mon_off     = 1'b1;
    bit   zl_flag     = 1'b0;

    always #5 clk = ~clk;

    multi_channel_capture #(
        .N_CH       (N_CH),
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .arm          (arm),
        .abort        (abort),
        .ext_trigger  (ext_trigger),
        .self_trig_en (self_trig_en),
        .threshold    (threshold),
        .trig_ch_mask (trig_ch_mask),
        .pre_count    (pre_count),
        .post_count   (post_count),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ch        (rd_ch),
        .rd_last      (rd_last),
        .armed        (armed),
        .done         (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] gen(input int mode, input int k, input int n);
        if (mode == 1) return WIDTH'($urandom);
        if (mode == 2 && ((k == 2 && n >= 20) || (k == 0 && n >= 15))) return WIDTH'(12'h900 + n);
        return WIDTH'(100 * k + n);
    endfunction

    function automatic bit ext_hit(input int n);
        foreach (ext_list[i]) if (ext_list[i] == n) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit self_hit(input logic [N_CH*WIDTH-1:0] s);
        for (int k = 0; k < N_CH; k++)
            if (trig_ch_mask[k] && s[k*WIDTH +: WIDTH] >= threshold) return 1'b1;
        return 1'b0;
    endfunction

    task automatic reset_checks(input string tag);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_ch"}, rd_ch, 0);
        check({tag, "_rd_last"}, rd_last, 0);
        check({tag, "_armed"}, armed, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Called at a falling edge; leaves the DUT idle and the scoreboard empty.
    task automatic do_abort(input logic with_arm);
        mon_off      = 1'b1;
        sample_valid = 1'b0;
        ext_trigger  = 1'b0;
        abort        = 1'b1;
        arm          = with_arm;
        @(negedge clk);
        abort = 1'b0;
        arm   = 1'b0;
        #2;
        check("abort_rd_valid", rd_valid, 0);
        check("abort_armed", armed, 0);
        repeat (4) begin
            @(negedge clk);
            #2;
            check("abort_no_done", done, 0);
            check("abort_idle_valid", rd_valid, 0);
        end
        exp_q.delete();
        mon_off = 1'b0;
    endtask

    task automatic do_reset();
        mon_off = 1'b1;
        #2 reset_n = 1'b0;
        #1 reset_checks("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        mon_off = 1'b0;
    endtask

    // abort_mode: 0 none, 1 abort in post window, 2 abort mid-readout, 3 reset mid-readout.
    task automatic run_capture(input int pre_req, input int post_req, input int data_mode,
                               input int valid_pct, input int trig_pct, input int abort_mode);
        int pre_c, post_c, len, wr, t, post_left, n, phase, cyc, pcyc;
        logic [N_CH*WIDTH-1:0] hist[$];
        logic [N_CH*WIDTH-1:0] smp;
        logic trig;
        exp_t e;
        pre_c   = (pre_req > DEPTH) ? DEPTH : pre_req;
        post_c  = (post_req > DEPTH - pre_c) ? DEPTH - pre_c : post_req;
        len     = pre_c + post_c;
        zl_flag = (len == 0);
        pre_count  = CW'(pre_req);
        post_count = CW'(post_req);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("armed_rise", armed, 1);
        wr = 0; n = 0; phase = 0; t = 0; post_left = 0; cyc = 0; pcyc = 0;
        while (phase != 2) begin
            sample_valid = ($urandom_range(99) < valid_pct);
            for (int k = 0; k < N_CH; k++) smp[k*WIDTH +: WIDTH] = gen(data_mode, k, n);
            sample_data = smp;
            if (trig_pct > 0) ext_trigger = ($urandom_range(99) < trig_pct);
            else ext_trigger = sample_valid && ext_hit(n);
            trig = ext_trigger || (self_trig_en && sample_valid && self_hit(smp));
            if (phase == 0) begin
                if (trig && wr >= pre_c) begin
                    t = wr;
                    if (post_c == 0) begin
                        phase = 2;
                    end else if (sample_valid) begin
                        hist.push_back(smp);
                        wr++;
                        post_left = post_c - 1;
                        phase = (post_left == 0) ? 2 : 1;
                    end else begin
                        post_left = post_c;
                        phase = 1;
                    end
                end else if (sample_valid) begin
                    hist.push_back(smp);
                    wr++;
                end
            end else begin
                pcyc++;
                if (sample_valid) begin
                    hist.push_back(smp);
                    wr++;
                    post_left--;
                    if (post_left == 0) phase = 2;
                end
            end
            if (sample_valid) n++;
            if (abort_mode == 1 && phase == 1 && pcyc == 3) begin
                do_abort(1'b0);
                zl_flag = 1'b0;
                return;
            end
            cyc++;
            if (cyc > 1000) begin
                check("trigger_timeout", 1, 0);
                do_abort(1'b0);
                zl_flag = 1'b0;
                return;
            end
            @(negedge clk);
        end
        sample_valid = 1'b0;
        ext_trigger  = 1'b0;
        for (int ch = 0; ch < N_CH; ch++) begin
            for (int i = 0; i < len; i++) begin
                smp    = hist[t - pre_c + i];
                e.data = smp[ch*WIDTH +: WIDTH];
                e.ch   = CH_W'(ch);
                e.last = (ch == N_CH - 1) && (i == len - 1);
                exp_q.push_back(e);
            end
        end
        if (len == 0) begin
            check("zl_done_early", done, 0);
            @(negedge clk);
            #2;
            check("zl_done", done, 1);
            check("zl_no_valid", rd_valid, 0);
            zl_flag = 1'b0;
        end else if (abort_mode >= 2) begin
            for (int i = 0; i < 500 && exp_q.size() > len * N_CH - 3; i++) @(negedge clk);
            check("mid_readout_reached", exp_q.size() <= len * N_CH - 3, 1);
            if (abort_mode == 2) do_abort(1'b0);
            else do_reset();
            return;
        end else begin
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                #2;
                if (done) break;
            end
            check("done_seen", done, 1);
            check("words_left", exp_q.size(), 0);
        end
        @(negedge clk);
        check("armed_fall", armed, 0);
    endtask

    initial begin
        rd_ready = 1'b0;
        forever begin
            @(negedge clk);
            rd_ready = ($urandom_range(99) < ready_pct);
        end
    end

    initial begin : monitor
        logic [31:0] hold;
        bit          stalled, last_hs, in_burst;
        exp_t        e;
        stalled = 0; last_hs = 0; in_burst = 0; hold = '0;
        forever begin
            @(negedge clk);
            #1;
            if (mon_off || !reset_n) begin
                stalled = 0; last_hs = 0; in_burst = 0;
            end else begin
                if (!zl_flag && (done || last_hs)) check("done_timing", done, last_hs);
                last_hs = 0;
                if (stalled) check("stall_stable", {rd_valid, rd_ch, rd_last, rd_data},
                                   {1'b1, hold[14:0]});
                stalled = 0;
                if (rd_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", {rd_ch, rd_last, rd_data}, 32'hffff_ffff);
                    end else begin
                        e = exp_q[0];
                        check("word", {rd_ch, rd_last, rd_data}, {e.ch, e.last, e.data});
                        if (rd_ready) begin
                            void'(exp_q.pop_front());
                            last_hs  = rd_last;
                            in_burst = (ready_pct == 100) && !rd_last;
                        end else begin
                            stalled = 1;
                            hold    = {17'd0, rd_ch, rd_last, rd_data};
                        end
                    end
                end else if (in_burst) begin
                    check("bubble", rd_valid, 1);
                    in_burst = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required $finish before %0t", $time);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;  sample_valid = 1'b0; sample_data = '0;  arm = 1'b0;
        abort = 1'b0;    ext_trigger = 1'b0;  self_trig_en = 1'b0; threshold = '0;
        trig_ch_mask = '0; pre_count = '0;    post_count = '0;
        repeat (2) @(negedge clk);
        #1 reset_checks("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        mon_off = 1'b0;

        // arm together with abort in idle must not arm
        arm = 1'b1; abort = 1'b1;
        @(negedge clk);
        arm = 1'b0; abort = 1'b0;
        check("arm_with_abort", armed, 0);

        ready_pct = 100;
        ext_list.delete(); ext_list.push_back(10);
        run_capture(4, 4, 0, 100, 0, 0);

        ext_list.delete();
        self_trig_en = 1'b1; threshold = 12'h800; trig_ch_mask = 4'b0100;
        run_capture(4, 4, 2, 100, 0, 0);
        self_trig_en = 1'b0;

        ext_list.push_back(3); ext_list.push_back(9);
        run_capture(8, 8, 0, 100, 0, 0);

        ext_list.delete(); ext_list.push_back(40);
        run_capture(10, 10, 0, 100, 0, 0);
        ext_list.delete();

        ready_pct = 50;
        for (int r = 0; r < 10; r++)
            run_capture(int'($urandom_range(20)), int'($urandom_range(20)), 1, 70, 10, 0);
        run_capture(0, 0, 0, 100, 20, 0);
        run_capture(20, 5, 1, 80, 10, 0);

        run_capture(4, 12, 1, 50, 10, 1);
        run_capture(6, 6, 1, 100, 10, 2);
        run_capture(6, 6, 1, 100, 10, 3);

        ready_pct = 100;
        ext_list.push_back(10);
        run_capture(4, 4, 0, 100, 0, 0);

        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
